smc_float_accumulator: RTL

//   Downstream consumer of the fixed-point-to-float converter. Takes the 32-bit

---
 rtl/smc_float_accumulator_if.sv | 28 ++
 rtl/smc_float_accumulator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/smc_float_accumulator_if.sv
// Sample/result bundle between the float converter,
// the accumulator and its consumer.
interface smc_float_accumulator_if;
  logic [31:0] x_i;
  logic        srdyi_i;
  logic [31:0] y_o;
  logic        srdyo_o;
  logic        busy_o;
  logic        drop_o;

  modport master (
    output x_i,
    output srdyi_i,
    input  y_o,
    input  srdyo_o,
    input  busy_o,
    input  drop_o
  );

  modport slave (
    input  x_i,
    input  srdyi_i,
    output y_o,
    output srdyo_o,
    output busy_o,
    output drop_o
  );
endinterface

// File: rtl/smc_float_accumulator.sv
// Sums N_SAMPLES single-precision words with a
// 3-cycle align/add/normalise datapath.
module smc_float_accumulator #(
  parameter int N_SAMPLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic                   Clock,
  input  logic                   GlobalReset,
  smc_float_accumulator_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_ADD   = 2'd2;
  localparam logic [1:0] S_NORM  = 2'd3;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_SAMPLES - 1);

  logic [1:0]       state;
  logic [31:0]      acc;
  logic [31:0]      xr;
  logic [31:0]      y_q;
  logic             srdyo_q;
  logic             drop_q;
  logic [CNT_W-1:0] cnt;

  logic             big_s;
  logic             sml_s;
  logic [7:0]       big_e;
  logic [23:0]      big_m;
  logic [23:0]      sml_m;
  logic [24:0]      mag;

  // {sign, exp, mantissa-with-hidden-bit}
  function automatic logic [32:0] dec(
    input logic [31:0] f
  );
    logic [32:0] r;
    if (f[30:23] == 8'd0)
      r = {f[31], 8'd0, 24'd0};
    else if (f[30:23] == 8'hFF)
      r = {f[31], 8'd254, 24'hFFFFFF};
    else
      r = {f[31], f[30:23], 1'b1, f[22:0]};
    return r;
  endfunction

  logic [32:0] da;
  logic [32:0] dx;
  logic [32:0] bo;
  logic [32:0] so;
  logic [7:0]  diff;
  logic [23:0] sml_al;

  // {exp,mant} compare orders magnitudes, mantissa breaks ties
  always_comb begin
    da   = dec(acc);
    dx   = dec(xr);
    bo   = (da[31:0] >= dx[31:0]) ? da : dx;
    so   = (da[31:0] >= dx[31:0]) ? dx : da;
    diff = bo[31:24] - so[31:24];
    if (so[23:0] == 24'd0 || diff > 8'd24)
      sml_al = 24'd0;
    else
      sml_al = so[23:0] >> diff;
  end

  logic [24:0] add_mag;

  always_comb begin
    if (big_s == sml_s)
      add_mag = {1'b0, big_m} + {1'b0, sml_m};
    else
      add_mag = {1'b0, big_m} - {1'b0, sml_m};
  end

  logic [4:0]        lz;
  logic              found;
  logic [23:0]       nm;
  logic signed [9:0] ne;
  logic [31:0]       res;

  always_comb begin
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && mag[i]) begin
        lz    = 5'(23 - i);
        found = 1'b1;
      end
    end
    if (mag[24]) begin
      nm = mag[24:1];
      ne = $signed({2'b00, big_e}) + 10'sd1;
    end else begin
      nm = mag[23:0] << lz;
      ne = $signed({2'b00, big_e})
         - $signed({5'd0, lz});
    end
    if (mag == 25'd0 || ne <= 10'sd0)
      res = 32'd0;
    else if (ne >= 10'sd255)
      res = {big_s, 31'h7F7FFFFF};
    else
      res = {big_s, ne[7:0], nm[22:0]};
  end

  always_ff @(posedge Clock) begin
    if (GlobalReset) begin
      state   <= S_IDLE;
      acc     <= 32'd0;
      xr      <= 32'd0;
      y_q     <= 32'd0;
      srdyo_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt     <= '0;
      big_s   <= 1'b0;
      sml_s   <= 1'b0;
      big_e   <= 8'd0;
      big_m   <= 24'd0;
      sml_m   <= 24'd0;
      mag     <= 25'd0;
    end else begin
      srdyo_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.srdyi_i) begin
            xr    <= bus.x_i;
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          big_s <= bo[32];
          big_e <= bo[31:24];
          big_m <= bo[23:0];
          sml_s <= so[32];
          sml_m <= sml_al;
          state <= S_ADD;
          if (bus.srdyi_i) drop_q <= 1'b1;
        end
        S_ADD: begin
          mag   <= add_mag;
          state <= S_NORM;
          if (bus.srdyi_i) drop_q <= 1'b1;
        end
        S_NORM: begin
          if (cnt == LAST) begin
            y_q     <= res;
            srdyo_q <= 1'b1;
            acc     <= 32'd0;
            cnt     <= '0;
          end else begin
            acc <= res;
            cnt <= cnt + 1'b1;
          end
          // the accumulator is written this edge,
          // so a back-to-back sample sees the new sum
          if (bus.srdyi_i) begin
            xr    <= bus.x_i;
            state <= S_ALIGN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.y_o     = y_q;
  assign bus.srdyo_o = srdyo_q;
  assign bus.busy_o  = (state != S_IDLE);
  assign bus.drop_o  = drop_q;

endmodule
